fifo_uart_tx: RTL and testbench

Read-side consumer for the team's 8-deep byte FIFO: pops bytes whenever the FIFO is non-empty and serializes each one as an 8N1 UART frame on `tx`. It sits between the FIFO read interface (`rd_en`/`data_out`/`empty`) and the board's UART pin. It honours the FIFO's one-cycle registered read latency: `data_out` is valid the cycle after `rd_en` is sampled.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 23 ++
 rtl/fifo_uart_tx.sv | 86 ++++++++
 tb/tb_fifo_uart_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and framing constants shared by the UART transmitter and receiver
package uart_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int DEFAULT_CLKS_PER_BIT = 104;
  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    LOAD  = ST_LOAD,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: down-counter pulsing bit_done on the last cycle of every CLKS_PER_BIT period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] TOP = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (clear || cnt_q == '0) ? TOP : cnt_q - 1'b1;
    bit_done = cnt_q == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= TOP;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the byte FIFO and serializes each byte as an 8N1 frame on tx
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);
  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             idx_q, idx_d;
  logic [15:0]            frames_q, frames_d;
  logic                   tx_q, tx_d, rd_q, rd_d, busy_q, busy_d;
  logic                   timer_clear, bit_done;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .bit_done (bit_done)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d = idx_q;
    frames_d = frames_q;
    timer_clear = 1'b0;
    case (state_q)
      IDLE:  state_d = (enable && !fifo_empty) ? REQ : IDLE;
      REQ:   state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
        timer_clear = 1'b1;
        state_d = START;
      end
      START: if (bit_done) begin
        idx_d = '0;
        state_d = DATA;
      end
      DATA: if (bit_done) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 3'd1;
        state_d = (idx_q == 3'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (bit_done) begin
        frames_d = frames_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with the state they describe
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    rd_d = state_d == REQ;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q <= '0;
      frames_q <= '0;
      tx_q <= 1'b1;
      rd_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      frames_q <= frames_d;
      tx_q <= tx_d;
      rd_q <= rd_d;
      busy_q <= busy_d;
    end
  end
  assign tx = tx_q;
  assign fifo_rd_en = rd_q;
  assign busy = busy_q;
  assign frames_sent = frames_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO model plus line-level UART reference checking fifo_uart_tx
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic fifo_rd_en, tx, busy;
  logic [15:0] frames_sent;
  logic push_v = 1'b0;
  logic [7:0] push_b = 8'h00;
  logic force_flag = 1'b0;
  logic [7:0] fq[$];
  logic [7:0] pushed[$];
  int checks = 0, fails = 0, cyc = 0;
  typedef struct {logic [7:0] data; logic [9:0] frame;} vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
    .frames_sent(frames_sent)
  );

  // 8-deep FIFO with registered read data; pushed[] keeps every accepted byte in order
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
    if (push_v && fq.size() < 8) begin
      fq.push_back(push_b);
      pushed.push_back(push_b);
    end
    fifo_empty <= fq.size() == 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a frame is {stop, byte LSB-first, start}, CPB cycles per bit, starting two
  // cycles after the read pulse; a read follows any idle cycle with enable and data present.
  task automatic monitor();
    logic inf = 1'b0, prev = 1'b0, exp_tx;
    logic [9:0] fr = '1;
    logic [15:0] mcnt = '0;
    int r = 0, idx = 0, off;
    forever begin
      @(negedge clk);
      cyc++;
      if (force_flag) mcnt = 16'hFFFF;
      if (!rst_n) begin
        inf = 1'b0;
        prev = 1'b0;
        mcnt = '0;
      end else begin
        if (prev) begin
          chk("m_pop_available", 32'(idx < pushed.size()), 1);
          fr = {1'b1, pushed[idx], 1'b0};
          idx++;
          inf = 1'b1;
          r = cyc;
        end
        chk("m_rd_en", 32'(fifo_rd_en), 32'(prev));
        off = cyc - r;
        exp_tx = (inf && off >= 2 && off < 2 + 10 * CPB) ? fr[(off - 2) / CPB] : 1'b1;
        chk("m_tx", 32'(tx), 32'(exp_tx));
        chk("m_busy", 32'(busy), 32'(inf));
        chk("m_frames_sent", 32'(frames_sent), 32'(mcnt));
        prev = !inf && enable && !fifo_empty;
        if (inf && off == 10 * CPB + 1) begin
          inf = 1'b0;
          mcnt++;
        end
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #1 push_v = 1'b1;
    push_b = b;
    @(posedge clk);
    #1 push_v = 1'b0;
  endtask

  task automatic wait_rd(output int r);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = fifo_rd_en;
    end
    chk("rd_en_timeout", 32'(got), 1);
    r = cyc;
  endtask

  // samples mid-bit of each of the 10 frame bits; ends on the first idle cycle after stop
  task automatic capture(input int drop_k, output logic [9:0] f, output int r);
    wait_rd(r);
    f = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      f[k] = tx;
      if (k == drop_k) begin
        @(posedge clk);
        #1 enable = 1'b0;
      end
      if (k < 9) repeat (CPB) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run();
    logic [9:0] f;
    int r, pr, n;
    bit done;
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_frames", 32'(frames_sent), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // reset during the start bit: byte lost, next byte sent intact
    enable = 1'b1;
    push(8'h11);
    wait_rd(r);
    repeat (3) @(negedge clk);
    chk("start_low", 32'(tx), 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", 32'(tx), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_frames", 32'(frames_sent), 0);
    push(8'h22);
    @(posedge clk);
    #1 rst_n = 1'b1;
    capture(-1, f, r);
    chk("after_abort_frame", 32'(f), 32'({1'b1, 8'h22, 1'b0}));
    chk("after_abort_frames", 32'(frames_sent), 1);
    // single-byte vectors
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].data);
      capture(-1, f, r);
      chk("tbl_frame", 32'(f), 32'(tbl[i].frame));
      chk("tbl_busy", 32'(busy), 0);
      chk("tbl_frames", 32'(frames_sent), 32'(pushed.size() - 1));
    end
    // burst from a full FIFO
    enable = 1'b0;
    for (int b = 0; b < 8; b++) push(8'(b));
    chk("burst_full", 32'(fq.size()), 8);
    @(posedge clk);
    #1 enable = 1'b1;
    pr = 0;
    for (int i = 0; i < 8; i++) begin
      capture(-1, f, r);
      chk("burst_frame", 32'(f), 32'({1'b1, 8'(i), 1'b0}));
      if (i > 0) chk("burst_period", 32'(r - pr), 32'(10 * CPB + 3));
      pr = r;
    end
    chk("burst_empty", 32'(fifo_empty), 1);
    chk("burst_frames", 32'(frames_sent), 32'(pushed.size() - 1));
    // enable dropped during data bit 3
    enable = 1'b0;
    push(8'h3C);
    push(8'hAA);
    push(8'hBB);
    @(posedge clk);
    #1 enable = 1'b1;
    capture(4, f, r);
    chk("drop_frame", 32'(f), 32'({1'b1, 8'h3C, 1'b0}));
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n += int'(fifo_rd_en);
    end
    chk("drop_no_rd", 32'(n), 0);
    chk("drop_left", 32'(fq.size()), 2);
    chk("drop_busy", 32'(busy), 0);
    @(posedge clk);
    #1 enable = 1'b1;
    capture(-1, f, r);
    chk("resume_frame0", 32'(f), 32'({1'b1, 8'hAA, 1'b0}));
    capture(-1, f, r);
    chk("resume_frame1", 32'(f), 32'({1'b1, 8'hBB, 1'b0}));
    // random traffic and enable toggling, checked by the monitor
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1 push_v = $urandom_range(0, 29) == 0;
      push_b = 8'($urandom);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
    end
    push_v = 1'b0;
    enable = 1'b1;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = fifo_empty && !busy;
    end
    chk("rand_drain", 32'(done), 1);
    chk("rand_frames", 32'(frames_sent), 32'(pushed.size() - 1));
    // frame counter wrap
    @(posedge clk);
    #1 force dut.frames_q = 16'hFFFF;
    force_flag = 1'b1;
    @(posedge clk);
    #1 release dut.frames_q;
    force_flag = 1'b0;
    @(negedge clk);
    chk("wrap_preset", 32'(frames_sent), 32'hFFFF);
    push(8'h5A);
    capture(-1, f, r);
    chk("wrap_frame", 32'(f), 32'({1'b1, 8'h5A, 1'b0}));
    chk("wrap_frames", 32'(frames_sent), 0);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h3C, 10'b1001111000};
    tbl[4] = '{8'h01, 10'b1000000010};
    tbl[5] = '{8'h80, 10'b1100000000};
    fork
      monitor();
      run();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
